interval_timer: RTL and testbench
=================================

# interval_timer

Parametrised multi-threshold interval timer for the traffic-light controller; it supersedes the fixed three-compare phase timer. A clock prescaler produces one tick per time unit. A CNT_W-bit unit counter is compared against N_THR run-time thresholds, which are latched at Start. The block supports hold/pause, one-shot or periodic mode, per-threshold level and pulse flags, and a remaining-time output for the countdown display.

## Interface
- DIV, 6000000: Clk cycles per tick (one time unit); ≥1
- CNT_W, 8: counter/threshold width, unsigned
- N_THR, 3: number of thresholds; index N_THR-1 is the terminal threshold
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  synchronous (re)start; latches Thr and Mode
- Hold  in  1  while high, prescaler and counter freeze
- Mode  in  1  0 = one-shot (stop at terminal), 1 = periodic (wrap at terminal)
- Thr  in  N_THR*CNT_W  packed thresholds; Thr[i*CNT_W +: CNT_W] is threshold i
- Reached  out  N_THR  level: armed & (count ≥ thr_q[i])
- Hit  out  N_THR  one-cycle pulse when count becomes equal to thr_q[i]
- Tick  out  1  one-cycle pulse per prescaler wrap while counting
- Wrap  out  1  one-cycle pulse on periodic wrap to 0
- Running  out  1  counting active
- Count  out  CNT_W  elapsed units
- Remain  out  CNT_W  thr_q[N_THR-1] - Count, modulo 2^CNT_W; 0 when not armed

## Operation
- Reset (async, Rst_n=0): pre=0, count=0, thr_q=0, mode_q=0, armed=0, Running=0.
  - All outputs 0, including Reached, because armed gates it.
- Start=1 at an edge:
  - Loads thr_q←Thr and mode_q←Mode; sets count=0, pre=0, armed=1.
  - Running←1, except Running←0 in one-shot mode with terminal threshold 0.
  - No Hit pulse on Start.
  - Start while Running restarts. Start overrides Hold in the same cycle.
- Counting occurs when Running & !Hold:
  - pre increments and wraps at DIV-1. Tick is asserted on the wrap edge.
  - On Tick, count_next = count+1.
  - When count == terminal at the tick:
    - one-shot: Running←0, count holds.
    - periodic: count←0, Wrap pulses.
  - Hit[i] is registered with the count update: it asserts for one cycle when count_next == thr_q[i]. In periodic mode this includes thr_q[i]==0 on a wrap.
- Periodic mode with terminal 0: count stays 0; Wrap and Hit[i] for thresholds equal to 0 pulse on every Tick.
- Hold=1: pre and count freeze, with no Tick, Hit or Wrap. Resuming continues from the frozen pre value.
- Thresholds need not be monotonic. In one-shot mode, a threshold above the terminal is never Reached or Hit.
- Thr and Mode changes outside Start have no effect.

## Timing
- Start at edge E0 (DIV=D): first Tick and count=1 at edge E0+D. Count k is reached at E0+k·D, excluding Hold cycles.
- Reached is combinational from registers, with zero latency after the count update.
- Hit, Tick and Wrap are registered and asserted for exactly the one cycle following the updating edge.
- DIV=1: Tick every cycle while counting.
- Rst_n asserted mid-count: immediate clear of all state. After release, the block stays idle until Start.

## Structure
- Package traffic_timer_pkg holds:
  - localparam TICKS_1S = 6000000
  - the mode encoding (MODE_ONESHOT=0, MODE_PERIODIC=1)
  - a function computing the prescaler width, max($clog2(DIV),1)
- Sub-module tick_prescaler (parameter DIV; ports Clk, Rst_n, clr, en, tick) encapsulates the pre counter.
- interval_timer holds the count, threshold latches, compare array (generate over N_THR) and mode logic.

## Test plan
All scenarios use DIV=4, CNT_W=4, N_THR=3 and Thr={14,4,1} (index 2..0) unless noted.
- Reset then no Start → all outputs 0 for 100 cycles; Reached=3'b000.
- One-shot Start at E0:
  - Hit[0] after E0+4 and Hit[1] after E0+16, each pulsed once.
  - Reached=3'b111 and Running=0 at E0+56. Count holds 14 and Remain=0 thereafter.
- Periodic, Thr={3,2,0}:
  - Count sequence 0,1,2,3,0 with Wrap and Hit[0] at E0+16 and every 16 cycles after.
  - Reached[2] is high for count=3 only.
- Hold high for 10 cycles starting at cycle E0+6 → count=1 edge unchanged at E0+4. Count=2 edge moves from E0+8 to E0+18, with no Tick during Hold.
- Restart at count=5 with new Thr={2,1,0} → count=0 next cycle and Reached=3'b001. Count=2 at +8 cycles, then Running=0.
- Edge cases:
  - One-shot with Thr terminal 0 → Running stays 0 and Reached=all ones after Start.
  - Rst_n pulsed low mid-count → all outputs 0 asynchronously.
  - Start coincident with Hold=1 → count=0, frozen until Hold falls.

Source files
------------

// File: rtl/traffic_timer_pkg.sv
// Shared constants, mode encoding and sizing helper for the traffic-light interval timer.
package traffic_timer_pkg;

  localparam int unsigned TICKS_1S = 6000000;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  // Width of a counter that must hold 0..div-1, never narrower than one bit.
  function automatic int unsigned pre_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to one strobe per time unit; tick is a combinational
// strobe that is high on the cycle whose edge wraps the prescaler.
module tick_prescaler
  import traffic_timer_pkg::*;
#(
  parameter int unsigned DIV = TICKS_1S
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = pre_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_pre;
  logic          w_last;

  assign w_last = (r_pre == LAST);
  assign tick   = en & ~clr & w_last;

  // NOTE: sequential state is only ever updated with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pre <= '0;
    end else if (clr) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_last ? '0 : r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Multi-threshold interval timer: counts prescaled time units against N_THR latched
// thresholds, with hold, one-shot/periodic mode, level and pulse flags and remaining time.
module interval_timer
  import traffic_timer_pkg::*;
#(
  parameter int unsigned DIV   = TICKS_1S,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned N_THR = 3
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Start,
  input  logic                     Hold,
  input  logic                     Mode,
  input  logic [N_THR*CNT_W-1:0]   Thr,
  output logic [N_THR-1:0]         Reached,
  output logic [N_THR-1:0]         Hit,
  output logic                     Tick,
  output logic                     Wrap,
  output logic                     Running,
  output logic [CNT_W-1:0]         Count,
  output logic [CNT_W-1:0]         Remain
);

  localparam int unsigned TERM = N_THR - 1;

  logic [N_THR-1:0][CNT_W-1:0] r_thr;
  mode_e                       r_mode;
  logic                        r_armed;
  logic                        r_running;
  logic [CNT_W-1:0]            r_count;
  logic [N_THR-1:0]            r_hit;
  logic                        r_tick;
  logic                        r_wrap;

  logic                        w_en;
  logic                        w_tick;
  logic                        w_at_term;
  logic                        w_wrap;
  logic                        w_advance;
  logic                        w_stop;
  logic [CNT_W-1:0]            w_term;
  logic [CNT_W-1:0]            w_start_term;
  logic [CNT_W-1:0]            w_count_next;
  logic [N_THR-1:0]            w_hit_next;

  assign w_term       = r_thr[TERM];
  assign w_start_term = Thr[TERM*CNT_W +: CNT_W];
  assign w_en         = r_running & ~Hold;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (Start),
    .en    (w_en),
    .tick  (w_tick)
  );

  // A one-shot timer sitting on its terminal holds; everything else moves on a tick.
  assign w_at_term    = (r_count == w_term);
  assign w_wrap       = w_tick & (r_mode == MODE_PERIODIC) & w_at_term;
  assign w_advance    = w_tick & ~((r_mode == MODE_ONESHOT) & w_at_term);
  assign w_count_next = w_wrap    ? '0 :
                        w_advance ? r_count + CNT_W'(1) : r_count;
  assign w_stop       = w_tick & (r_mode == MODE_ONESHOT) &
                        (w_at_term | (w_count_next == w_term));

  for (genvar g = 0; g < N_THR; g++) begin : g_cmp
    assign w_hit_next[g] = w_advance & (w_count_next == r_thr[g]);
    assign Reached[g]    = r_armed & (r_count >= r_thr[g]);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_thr     <= '0;
      r_mode    <= MODE_ONESHOT;
      r_armed   <= 1'b0;
      r_running <= 1'b0;
      r_count   <= '0;
      r_hit     <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (Start) begin
      r_thr     <= Thr;
      r_mode    <= mode_e'(Mode);
      r_armed   <= 1'b1;
      r_running <= Mode | (w_start_term != '0);
      r_count   <= '0;
      r_hit     <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_hit   <= w_hit_next;
      r_tick  <= w_tick;
      r_wrap  <= w_wrap;
      if (w_stop) begin
        r_running <= 1'b0;
      end
    end
  end

  assign Hit     = r_hit;
  assign Tick    = r_tick;
  assign Wrap    = r_wrap;
  assign Running = r_running;
  assign Count   = r_count;
  assign Remain  = r_armed ? (w_term - r_count) : '0;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: vector table, directed corner sequences and
// randomized traffic compared against an elapsed-time reference model.
module tb_interval_timer;
  import traffic_timer_pkg::*;

  localparam int DIV   = 4;
  localparam int CNT_W = 4;
  localparam int N_THR = 3;

  logic                   Clk   = 1'b0;
  logic                   Rst_n = 1'b0;
  logic                   Start = 1'b0;
  logic                   Hold  = 1'b0;
  logic                   Mode  = 1'b0;
  logic [N_THR*CNT_W-1:0] Thr   = '0;
  logic [N_THR-1:0]       Reached, Hit;
  logic                   Tick, Wrap, Running;
  logic [CNT_W-1:0]       Count, Remain;
  logic [17:0]            dut_vec;

  interval_timer #(.DIV(DIV), .CNT_W(CNT_W), .N_THR(N_THR)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .Hold    (Hold),
    .Mode    (Mode),
    .Thr     (Thr),
    .Reached (Reached),
    .Hit     (Hit),
    .Tick    (Tick),
    .Wrap    (Wrap),
    .Running (Running),
    .Count   (Count),
    .Remain  (Remain)
  );

  assign dut_vec = {Reached, Hit, Tick, Wrap, Running, Count, Remain};

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the timer is described by the number of counting cycles since
  // Start; elapsed units follow by division and the count by the mode rule.
  bit m_armed;
  bit m_mode;
  int m_thr[N_THR];
  int m_active;
  bit m_evt;

  function automatic int m_units();
    return m_active / DIV;
  endfunction

  function automatic int m_count();
    int u = m_units();
    int t = m_thr[N_THR-1];
    if (!m_armed) return 0;
    if (m_mode) return u % (t + 1);
    return (u < t) ? u : t;
  endfunction

  function automatic bit m_running();
    return m_armed && (m_mode || m_units() < m_thr[N_THR-1]);
  endfunction

  function automatic logic [17:0] m_expect();
    int c = m_count();
    int t = m_thr[N_THR-1];
    logic [2:0] r, h;
    logic [3:0] rem;
    for (int i = 0; i < N_THR; i++) begin
      r[i] = m_armed && (c >= m_thr[i]);
      h[i] = m_evt && (c == m_thr[i]);
    end
    rem = m_armed ? 4'(t - c) : 4'd0;
    return {r, h, m_evt, m_evt && m_mode && (c == 0), m_running(), 4'(c), rem};
  endfunction

  task automatic model_reset();
    m_armed  = 0;
    m_mode   = 0;
    m_active = 0;
    m_evt    = 0;
    for (int i = 0; i < N_THR; i++) m_thr[i] = 0;
  endtask

  task automatic model_update(input bit s, input bit h, input bit md, input logic [11:0] th);
    bit run = m_running();
    m_evt = 0;
    if (s) begin
      m_armed  = 1;
      m_mode   = md;
      m_active = 0;
      for (int i = 0; i < N_THR; i++) m_thr[i] = int'(th[i*CNT_W +: CNT_W]);
    end else if (run && !h) begin
      m_active++;
      if (m_active % DIV == 0) m_evt = 1;
    end
  endtask

  // One clock: capture inputs, advance the model on the edge, settle 1 time unit.
  task automatic step();
    bit s = Start, h = Hold, md = Mode, rn = Rst_n;
    logic [11:0] th = Thr;
    @(posedge Clk);
    if (!rn) model_reset();
    else     model_update(s, h, md, th);
    #1;
  endtask

  task automatic check_model(input string nm);
    check(nm, dut_vec, m_expect());
  endtask

  task automatic run(input int n, input string nm);
    repeat (n) begin
      step();
      check_model(nm);
    end
  endtask

  task automatic do_start(input bit md, input logic [11:0] th);
    Start = 1'b1;
    Mode  = md;
    Thr   = th;
    step();
    check_model("start");
    Start = 1'b0;
    Mode  = 1'($urandom);
    Thr   = 12'($urandom);
  endtask

  typedef struct {
    bit         mode;
    logic [11:0] thr;
    int         k;
    logic [3:0] cnt;
    logic [2:0] reached;
    bit         running;
    logic [3:0] remain;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n0, n1, n2, p0, p1, p2, nt, nw, nh0, badw, badh, c1, c2, tk, found;

    tbl[0]  = '{1'b0, 12'hE41,  0, 4'd0,  3'b000, 1'b1, 4'd14};
    tbl[1]  = '{1'b0, 12'hE41,  4, 4'd1,  3'b001, 1'b1, 4'd13};
    tbl[2]  = '{1'b0, 12'hE41, 16, 4'd4,  3'b011, 1'b1, 4'd10};
    tbl[3]  = '{1'b0, 12'hE41, 56, 4'd14, 3'b111, 1'b0, 4'd0};
    tbl[4]  = '{1'b0, 12'hE41, 70, 4'd14, 3'b111, 1'b0, 4'd0};
    tbl[5]  = '{1'b1, 12'h320,  8, 4'd2,  3'b011, 1'b1, 4'd1};
    tbl[6]  = '{1'b1, 12'h320, 12, 4'd3,  3'b111, 1'b1, 4'd0};
    tbl[7]  = '{1'b1, 12'h320, 16, 4'd0,  3'b001, 1'b1, 4'd3};
    tbl[8]  = '{1'b0, 12'h000, 20, 4'd0,  3'b111, 1'b0, 4'd0};
    tbl[9]  = '{1'b0, 12'h9C3, 36, 4'd9,  3'b101, 1'b0, 4'd0};
    tbl[10] = '{1'b1, 12'h000,  8, 4'd0,  3'b111, 1'b1, 4'd0};

    model_reset();

    // Reset and stay idle without Start.
    repeat (3) step();
    check("reset outputs", dut_vec, 18'h0);
    Rst_n = 1'b1;
    repeat (100) begin
      step();
      check("idle outputs", dut_vec, 18'h0);
    end

    // Vector table: state k edges after Start.
    for (int r = 0; r < 11; r++) begin
      do_start(tbl[r].mode, tbl[r].thr);
      run(tbl[r].k, "vec run");
      check($sformatf("vec%0d cnt/reach/run/rem", r), {Count, Reached, Running, Remain},
            {tbl[r].cnt, tbl[r].reached, tbl[r].running, tbl[r].remain});
    end

    // One-shot pulse positions and counts.
    do_start(1'b0, 12'hE41);
    n0 = 0; n1 = 0; n2 = 0; p0 = -1; p1 = -1; p2 = -1; nt = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      check_model("oneshot");
      if (Hit[0]) begin n0++; p0 = k; end
      if (Hit[1]) begin n1++; p1 = k; end
      if (Hit[2]) begin n2++; p2 = k; end
      if (Tick) nt++;
    end
    check("oneshot hit0 pulses", n0, 1);
    check("oneshot hit0 edge", p0, 4);
    check("oneshot hit1 pulses", n1, 1);
    check("oneshot hit1 edge", p1, 16);
    check("oneshot hit2 edge", p2, 56);
    check("oneshot tick total", nt, 14);

    // Periodic wraps every 16 cycles.
    do_start(1'b1, 12'h320);
    nw = 0; nh0 = 0; badw = 0; badh = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      check_model("periodic");
      if (Wrap) begin nw++; if (k % 16 != 0) badw++; end
      if (Hit[0]) begin nh0++; if (k % 16 != 0) badh++; end
    end
    check("periodic wraps", nw, 3);
    check("periodic wrap misplaced", badw, 0);
    check("periodic hit0 pulses", nh0, 3);
    check("periodic hit0 misplaced", badh, 0);

    // Hold for 10 cycles after edge 6 delays count=2 from edge 8 to 18.
    do_start(1'b0, 12'hE41);
    c1 = -1; c2 = -1; tk = 0;
    for (int k = 1; k <= 30; k++) begin
      Hold = (k >= 7 && k <= 16);
      step();
      check_model("hold");
      if (Count == 4'd1 && c1 < 0) c1 = k;
      if (Count == 4'd2 && c2 < 0) c2 = k;
      if (Hold && Tick) tk++;
    end
    Hold = 1'b0;
    check("hold count1 edge", c1, 4);
    check("hold count2 edge", c2, 18);
    check("hold ticks", tk, 0);

    // Restart at count 5 with new thresholds.
    do_start(1'b0, 12'hE41);
    found = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      check_model("pre-restart");
      if (Count == 4'd5) begin found = k; break; end
    end
    check("restart count5 edge", found, 20);
    do_start(1'b0, 12'h210);
    check("restart cnt/reach/run", {Count, Reached, Running}, {4'd0, 3'b001, 1'b1});
    run(8, "restart run");
    check("restart end cnt/run", {Count, Running}, {4'd2, 1'b0});

    // Asynchronous reset mid-count.
    do_start(1'b0, 12'hE41);
    run(10, "pre-reset");
    Rst_n = 1'b0;
    #1;
    check("async reset outputs", dut_vec, 18'h0);
    model_reset();
    repeat (2) step();
    Rst_n = 1'b1;
    run(10, "post reset");
    check("post reset idle", {Count, Running}, 5'd0);

    // Start together with Hold: armed at 0, frozen until Hold falls.
    Hold = 1'b1;
    do_start(1'b0, 12'hE41);
    run(5, "start+hold");
    check("start+hold frozen", {Count, Running, Tick}, {4'd0, 1'b1, 1'b0});
    Hold = 1'b0;
    run(3, "hold released");
    check("hold released cnt", Count, 4'd0);
    run(1, "hold released");
    check("hold released first unit", Count, 4'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      Start = ($urandom % 30 == 0);
      Hold  = ($urandom % 4 == 0);
      Mode  = 1'($urandom);
      Thr   = 12'($urandom);
      if ($urandom % 2 == 0) Thr[11:8] = 4'($urandom % 6);
      step();
      check_model("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
